// File: rtl/pll_rst_pkg.sv
// Shared types and helpers for the PLL reset sequencer.
package pll_rst_pkg;

  localparam int RETRY_W = 4;

  typedef enum logic [2:0] {
    S_PLL_RST,
    S_WAIT_LOCK,
    S_STABLE,
    S_RELEASE,
    S_RUN,
    S_FAULT
  } state_t;

  // Width of the shared state counter: enough to reach the longest per-state interval.
  function automatic int cnt_width(input int rst_cycles, input int timeout_cycles,
                                   input int stable_cycles, input int release_cycles);
    int m;
    m = rst_cycles;
    if (timeout_cycles > m) m = timeout_cycles;
    if (stable_cycles > m) m = stable_cycles;
    if (release_cycles > m) m = release_cycles;
    return $clog2(m + 1);
  endfunction

endpackage

// File: rtl/sync_2ff.sv
// Single-bit double-flop synchroniser with asynchronous active-low reset to 0.
module sync_2ff (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic meta;

  // Two-stage capture of the asynchronous input into the clk domain.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta <= 1'b0;
      q    <= 1'b0;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/pll_reset_sequencer.sv
// PLL supervisor: resets the PLL, waits for a stable lock, then releases the
// per-domain resets one at a time. Failed or timed-out lock attempts retry the
// PLL reset; too many consecutive failures latch a sticky fault.
module pll_reset_sequencer
  import pll_rst_pkg::*;
#(
  parameter int PLL_RST_CYCLES      = 16,
  parameter int LOCK_STABLE_CYCLES  = 1024,
  parameter int LOCK_TIMEOUT_CYCLES = 74250,
  parameter int NUM_RESETS          = 5,
  parameter int STAGE_GAP           = 16,
  parameter int MAX_RETRIES         = 7
) (
  input  logic                  clk_74a,
  input  logic                  reset_n,
  input  logic                  force_reset,
  input  logic                  pll_locked,
  output logic                  pll_rst,
  output logic [NUM_RESETS-1:0] sys_rst_n,
  output logic                  ready,
  output logic                  fault,
  output logic [RETRY_W-1:0]    retry_count
);

  localparam int CNT_W = cnt_width(PLL_RST_CYCLES, LOCK_TIMEOUT_CYCLES,
                                   LOCK_STABLE_CYCLES, NUM_RESETS * STAGE_GAP);

  state_t                  state, state_d;
  logic [CNT_W-1:0]        cnt, cnt_d;
  logic [RETRY_W-1:0]      retry_d;
  logic [NUM_RESETS-1:0]   rel_d;
  logic                    lock_s;
  logic                    fail;

  sync_2ff u_lock_sync (
    .clk   (clk_74a),
    .rst_n (reset_n),
    .d     (pll_locked),
    .q     (lock_s)
  );

  // Next-state, counter and output decisions; all outputs are registered from these.
  always_comb begin
    state_d = state;
    retry_d = retry_count;
    rel_d   = sys_rst_n;
    fail    = 1'b0;

    case (state)
      S_PLL_RST: begin
        if (cnt == CNT_W'(PLL_RST_CYCLES - 1)) state_d = S_WAIT_LOCK;
      end
      S_WAIT_LOCK: begin
        // A lock arriving on the timeout cycle still counts as success.
        if (lock_s) state_d = S_STABLE;
        else if (cnt == CNT_W'(LOCK_TIMEOUT_CYCLES - 1)) fail = 1'b1;
      end
      S_STABLE: begin
        if (!lock_s) fail = 1'b1;
        else if (cnt == CNT_W'(LOCK_STABLE_CYCLES - 1)) state_d = S_RELEASE;
      end
      S_RELEASE: begin
        // Lock loss beats any release scheduled on the same cycle.
        if (!lock_s) begin
          fail = 1'b1;
        end else begin
          for (int i = 0; i < NUM_RESETS; i++) begin
            if (cnt == CNT_W'((i + 1) * STAGE_GAP - 1)) rel_d[i] = 1'b1;
          end
          if (cnt == CNT_W'(NUM_RESETS * STAGE_GAP - 1)) state_d = S_RUN;
        end
      end
      S_RUN: begin
        // Losing lock after a good run restarts cleanly; it is not a failed attempt.
        if (!lock_s) begin
          state_d = S_PLL_RST;
          retry_d = '0;
          rel_d   = '0;
        end
      end
      S_FAULT: begin
        state_d = S_FAULT;
      end
      default: begin
        state_d = S_PLL_RST;
      end
    endcase

    if (fail) begin
      retry_d = retry_count + RETRY_W'(1);
      rel_d   = '0;
      state_d = (retry_d == RETRY_W'(MAX_RETRIES)) ? S_FAULT : S_PLL_RST;
    end

    if (force_reset) begin
      state_d = S_PLL_RST;
      retry_d = '0;
      rel_d   = '0;
    end

    // Counter restarts on every state entry, including a forced re-entry of S_PLL_RST.
    if ((state_d != state) || force_reset) cnt_d = '0;
    else                                   cnt_d = cnt + CNT_W'(1);
  end

  // State, counter and registered outputs.
  always_ff @(posedge clk_74a or negedge reset_n) begin
    if (!reset_n) begin
      state       <= S_PLL_RST;
      cnt         <= '0;
      pll_rst     <= 1'b1;
      sys_rst_n   <= '0;
      ready       <= 1'b0;
      fault       <= 1'b0;
      retry_count <= '0;
    end else begin
      state       <= state_d;
      cnt         <= cnt_d;
      pll_rst     <= (state_d == S_PLL_RST);
      sys_rst_n   <= rel_d;
      ready       <= (state_d == S_RUN);
      fault       <= (state_d == S_FAULT);
      retry_count <= retry_d;
    end
  end

endmodule
